// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage
// Presents PC to instruction memory, captures the returned word into a
// one-entry instruction register for decode, and pulses pc_advance so
// control selects PC <= PC+4 on the same edge as the capture.
// Optional feature: define FETCH_TIMEOUT_EN to build the request timeout
// counter that drives the sticky fetch_fault flag.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no request; gives the PC one cycle to load a branch target
// REQUEST | request issued whenever IR is empty or being consumed
module instruction_fetch_stage #(
    parameter int N       = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] PC,
    input  logic         stall,
    input  logic         flush,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_ready,
    output logic [N-1:0] mem_addr,
    output logic         mem_req,
    output logic [N-1:0] IR,
    output logic [N-1:0] IR_PC,
    output logic         IR_valid,
    output logic         pc_advance,
    output logic         fetch_fault
);

    typedef enum logic {
        IDLE    = 1'b0,
        REQUEST = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept;

    assign mem_addr = PC;

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, request and accept decode. A flush always lands in IDLE,
    // including a flush that arrives while already idle.
    always_comb begin
        state_next = REQUEST;
        mem_req    = 1'b0;
        accept     = 1'b0;
        if (state == REQUEST) begin
            mem_req = !IR_valid || !stall;
        end
        accept = mem_req && mem_ready && !flush;
        if (flush) begin
            state_next = IDLE;
        end
    end

    assign pc_advance = accept;

    // Instruction register: flush kills it, accept loads it, consumption
    // empties it, and a stalled live entry is held untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            IR       <= '0;
            IR_PC    <= '0;
            IR_valid <= 1'b0;
        end else if (flush) begin
            IR_valid <= 1'b0;
        end else if (accept) begin
            IR       <= mem_rdata;
            IR_PC    <= PC;
            IR_valid <= 1'b1;
        end else if (IR_valid && !stall) begin
            IR_valid <= 1'b0;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_LOG = $clog2(TIMEOUT + 1);
    localparam int TW      = (CNT_LOG < 8) ? 8 : ((CNT_LOG > 32) ? 32 : CNT_LOG);
    localparam logic [TW-1:0] TERM = TW'(TIMEOUT);

    logic [TW-1:0] wait_cnt;
    logic          fault_q;

    // Count unanswered request cycles; saturate at the terminal value so the
    // counter never wraps while memory stays silent.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else if (accept || flush || (state == IDLE)) begin
            wait_cnt <= '0;
        end else if (mem_req && !mem_ready) begin
            if (wait_cnt != TERM) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (wait_cnt == TERM - 1'b1) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign fetch_fault = fault_q;
`else
    // No counter built; TIMEOUT is referenced only so the parameter stays
    // meaningful to the elaborator, and the AND folds to constant 0.
    assign fetch_fault = 1'b0 & (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: cycle-level reference model plus a
// scoreboard of {instruction, address} pairs pushed when a fetch is expected
// to be accepted and popped after the capturing edge.
module tb_instruction_fetch_stage;

    localparam int N  = 32;
    localparam int TO = 8;

    logic         clock;
    logic         reset;
    logic [N-1:0] PC;
    logic         stall;
    logic         flush;
    logic [N-1:0] mem_rdata;
    logic         mem_ready;
    logic [N-1:0] mem_addr;
    logic         mem_req;
    logic [N-1:0] IR;
    logic [N-1:0] IR_PC;
    logic         IR_valid;
    logic         pc_advance;
    logic         fetch_fault;

    instruction_fetch_stage #(.N(N), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .PC          (PC),
        .stall       (stall),
        .flush       (flush),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .IR          (IR),
        .IR_PC       (IR_PC),
        .IR_valid    (IR_valid),
        .pc_advance  (pc_advance),
        .fetch_fault (fetch_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [63:0] sb[$];

    logic         m_req_state;
    logic         m_valid;
    logic [N-1:0] m_ir;
    logic [N-1:0] m_irpc;
    logic         m_fault;
    int           m_cnt;
    logic [N-1:0] pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req_state = 1'b0;
        m_valid     = 1'b0;
        m_ir        = '0;
        m_irpc      = '0;
        m_fault     = 1'b0;
        m_cnt       = 0;
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".mem_req"}, 32'(mem_req), 32'd0);
        check({tag, ".pc_advance"}, 32'(pc_advance), 32'd0);
        check({tag, ".IR_valid"}, 32'(IR_valid), 32'd0);
        check({tag, ".IR"}, IR, 32'd0);
        check({tag, ".IR_PC"}, IR_PC, 32'd0);
        check({tag, ".fetch_fault"}, 32'(fetch_fault), 32'd0);
    endtask

    // One clock cycle: drive, check combinational outputs mid-cycle, advance
    // the model, then compare any scoreboarded capture after the edge.
    task automatic cycle(input logic st, input logic fl, input logic rdy, input logic [N-1:0] rd);
        logic        e_req;
        logic        e_acc;
        logic [63:0] exp;
        stall     = st;
        flush     = fl;
        mem_ready = rdy;
        mem_rdata = rd;
        PC        = pc;
        @(negedge clock);
        e_req = m_req_state && (!m_valid || !st);
        e_acc = e_req && rdy && !fl;
        check("mem_req", 32'(mem_req), 32'(e_req));
        check("pc_advance", 32'(pc_advance), 32'(e_acc));
        check("mem_addr", mem_addr, pc);
        check("IR_valid", 32'(IR_valid), 32'(m_valid));
        check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        if (m_valid) begin
            check("IR_held", IR, m_ir);
            check("IR_PC_held", IR_PC, m_irpc);
        end
        if (e_acc) sb.push_back({rd, pc});
`ifdef FETCH_TIMEOUT_EN
        if (fl || !m_req_state || e_acc) begin
            m_cnt = 0;
        end else if (e_req && !rdy) begin
            m_cnt++;
            if (m_cnt >= TO) m_fault = 1'b1;
        end
`endif
        if (fl) begin
            m_valid     = 1'b0;
            m_req_state = 1'b0;
        end else begin
            m_req_state = 1'b1;
            if (e_acc) begin
                m_valid = 1'b1;
                m_ir    = rd;
                m_irpc  = pc;
            end else if (m_valid && !st) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        if (e_acc) begin
            if (sb.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                exp = sb.pop_front();
                check("IR", IR, exp[63:32]);
                check("IR_PC", IR_PC, exp[31:0]);
                check("IR_valid_after_accept", 32'(IR_valid), 32'd1);
            end
            pc = pc + 32'd4;
        end
    endtask

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        PC        = '0;
        pc        = '0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Zero-wait streaming from PC 0.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 32'hA000_0000 | pc);

        // Stall with a live IR holds it and suppresses requests.
        cycle(1'b0, 1'b0, 1'b1, 32'h8B02_0020);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'h1111_1111);
        cycle(1'b0, 1'b0, 1'b1, 32'hB000_0000 | pc);

        // Flush collides with returning data; branch target 0x100.
        cycle(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        pc = 32'h100;
        cycle(1'b0, 1'b0, 1'b1, 32'h5555_5555);
        cycle(1'b0, 1'b0, 1'b1, 32'hC000_0000 | pc);

        // Four wait states then a single accept.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'h7777_7777);
        cycle(1'b0, 1'b0, 1'b1, 32'hD000_0000 | pc);

        // Flush twice in a row, then a stalled empty IR still fills.
        cycle(1'b0, 1'b1, 1'b1, 32'h0BAD_0001);
        cycle(1'b0, 1'b1, 1'b1, 32'h0BAD_0002);
        pc = 32'h200;
        cycle(1'b1, 1'b0, 1'b1, 32'h0BAD_0003);
        cycle(1'b1, 1'b0, 1'b1, 32'hE000_0000 | pc);
        cycle(1'b0, 1'b0, 1'b1, 32'hE100_0000 | pc);

        // Long silence: timeout fault (when built) must stick afterwards.
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 32'h3333_3333);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 32'hF000_0000 | pc);

        // Random mix of stalls, flushes and wait states.
        for (int i = 0; i < 80; i++) begin
            logic st;
            logic fl;
            logic rdy;
            st  = 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            cycle(st, fl, rdy, $urandom());
            if (fl) pc = {22'($urandom_range(0, 1023)), 8'h00, 2'b00};
        end

        // Reset lands while a request is outstanding with data arriving.
        cycle(1'b0, 1'b0, 1'b1, 32'h1234_5678 | pc);
        stall     = 1'b0;
        flush     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h9999_9999;
        PC        = pc;
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_async");
        @(posedge clock);
        #1;
        check_reset_outputs("reset_held");
        reset = 1'b0;
        model_reset();
        pc = 32'h40;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 32'h4000_0000 | pc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
